// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache hierarchy.
// Covers the victim-cache write-back buffer state machine and its entry layout.
package lc3b_types;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } vc_wb_state_t;

  typedef struct packed {
    logic         valid;
    logic [11:0]  addr;
    logic [127:0] data;
  } vc_wb_entry_t;

endpackage

// File: rtl/vc_wb_cam.sv
// DEPTH-way line-address comparator for the write-back buffer.
// When several entries match, the youngest one (closest to tail) wins.
module vc_wb_cam #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0]          key,
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0]           exclude,
  input  logic [ADDR_W-1:0]          addrs [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   tail,
  output logic                       hit,
  output logic [$clog2(DEPTH)-1:0]   idx
);
  import lc3b_types::*;

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] match;
  logic [PW-1:0]    pos;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = valid[gi] & ~exclude[gi] & (addrs[gi] == key);
    end
  endgenerate

  // Walk backwards from tail-1 so the first match found is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      pos = tail - PW'(k);
      if (!hit && match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/vc_wb_buffer.sv
// Write-back buffer for dirty victim-cache lines: coalescing circular queue,
// combinational forwarding lookup, and a one-line-at-a-time pmem drain.
module vc_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enq_valid,
  input  logic [ADDR_W-1:0]            enq_addr,
  input  logic [DATA_W-1:0]            enq_data,
  output logic                         enq_ready,
  input  logic [ADDR_W-1:0]            lookup_addr,
  output logic                         lookup_hit,
  output logic [DATA_W-1:0]            lookup_data,
  output logic [ADDR_W+3:0]            pmem_address,
  output logic [DATA_W-1:0]            pmem_wdata,
  output logic                         pmem_write,
  input  logic                         pmem_resp,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  import lc3b_types::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  vc_wb_state_t      state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [DEPTH-1:0]  head_mask, coal_excl;
  logic              coal_hit, accept, push_new, pop;
  logic [PW-1:0]     coal_idx, look_idx;

  // The head being written to memory is frozen, so it is hidden from coalescing.
  assign head_mask = DEPTH'(1) << head_q;
  assign coal_excl = (state_q == WRITE) ? head_mask : '0;

  vc_wb_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_coal_cam (
    .key     (enq_addr),
    .valid   (valid_q),
    .exclude (coal_excl),
    .addrs   (addr_q),
    .tail    (tail_q),
    .hit     (coal_hit),
    .idx     (coal_idx)
  );

  vc_wb_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_look_cam (
    .key     (lookup_addr),
    .valid   (valid_q),
    .exclude ('0),
    .addrs   (addr_q),
    .tail    (tail_q),
    .hit     (lookup_hit),
    .idx     (look_idx)
  );

  assign lookup_data = lookup_hit ? data_q[look_idx] : '0;

  assign enq_ready = !full_q | coal_hit;
  assign accept    = enq_valid & enq_ready;
  assign push_new  = accept & ~coal_hit;
  assign pop       = (state_q == WRITE) & pmem_resp;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;

    if (accept && coal_hit) begin
      data_d[coal_idx] = enq_data;
    end
    if (push_new) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = enq_addr;
      data_d[tail_q]  = enq_data;
      tail_d          = tail_q + PW'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (push_new && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_new && pop) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty_q)  state_d = WRITE;
      WRITE:   if (pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign pmem_write   = (state_q == WRITE);
  assign pmem_address = pmem_write ? {addr_q[head_q], 4'b0000} : '0;
  assign pmem_wdata   = pmem_write ? data_q[head_q] : '0;

  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_vc_wb_buffer.sv
// Scoreboard bench for vc_wb_buffer: every drained line is checked against the
// queue of lines the bench expects memory to receive, in order.
module tb_vc_wb_buffer;

  logic         clk;
  logic         rst_n;
  logic         enq_valid;
  logic [11:0]  enq_addr;
  logic [127:0] enq_data;
  logic         enq_ready;
  logic [11:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_write;
  logic         pmem_resp;
  logic [2:0]   count;
  logic         empty;
  logic         full;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  logic [11:0]  sb_addr [$];
  logic [127:0] sb_data [$];

  vc_wb_buffer #(.DEPTH(4), .ADDR_W(12), .DATA_W(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq_valid    (enq_valid),
    .enq_addr     (enq_addr),
    .enq_data     (enq_data),
    .enq_ready    (enq_ready),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Completed writes are compared against the oldest expected line.
  always @(negedge clk) begin
    if (rst_n && pmem_write && pmem_resp) begin
      if (sb_addr.size() == 0) begin
        check_eq("sb_unexpected_write", {112'd0, pmem_address}, 128'd0);
      end else begin
        check_eq("pmem_address", {112'd0, pmem_address}, {112'd0, sb_addr[0], 4'b0000});
        check_eq("pmem_wdata", pmem_wdata, sb_data[0]);
        void'(sb_addr.pop_front());
        void'(sb_data.pop_front());
      end
      n_writes++;
    end
  end

  // Call at posedge+1; accepts one line and applies the coalescing rule to the model.
  task automatic enq(input logic [11:0] a, input logic [127:0] d);
    bit frozen, popped, rdy, co;
    int lo;
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    @(negedge clk);
    frozen = pmem_write;
    popped = pmem_write && pmem_resp;
    rdy    = enq_ready;
    check_eq("enq_ready", {127'd0, rdy}, 128'd1);
    #1;
    if (rdy) begin
      lo = (frozen && !popped) ? 1 : 0;
      co = 1'b0;
      for (int j = sb_addr.size() - 1; j >= lo; j--) begin
        if (!co && sb_addr[j] == a) begin
          sb_data[j] = d;
          co = 1'b1;
        end
      end
      if (!co) begin
        sb_addr.push_back(a);
        sb_data.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [11:0] a, input logic h, input logic [127:0] d);
    lookup_addr = a;
    #1;
    check_eq({tag, "_hit"}, {127'd0, lookup_hit}, {127'd0, h});
    check_eq({tag, "_data"}, lookup_data, d);
  endtask

  // Answers each write after lat cycles until the model queue is empty.
  task automatic drain_all(input int lat, input int maxcyc);
    int cyc = 0;
    int w = 0;
    pmem_resp = 1'b0;
    while (sb_addr.size() != 0 && cyc < maxcyc) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        w = 0;
      end else if (pmem_write) begin
        if (w >= lat) pmem_resp = 1'b1;
        else w++;
      end
    end
    if (pmem_resp) begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
    end
    if (cyc >= maxcyc) check_eq("drain_timeout", 128'(sb_addr.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] d1, d2;
    int w0;
    rst_n       = 1'b0;
    enq_valid   = 1'b0;
    enq_addr    = '0;
    enq_data    = '0;
    lookup_addr = '0;
    pmem_resp   = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_empty", {127'd0, empty}, 128'd1);
    check_eq("rst_full", {127'd0, full}, 128'd0);
    check_eq("rst_count", {125'd0, count}, 128'd0);
    check_eq("rst_enq_ready", {127'd0, enq_ready}, 128'd1);
    check_eq("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
    check_eq("rst_pmem_address", {112'd0, pmem_address}, 128'd0);
    check_eq("rst_pmem_wdata", pmem_wdata, 128'd0);
    check_eq("rst_lookup_hit", {127'd0, lookup_hit}, 128'd0);
    check_eq("rst_lookup_data", lookup_data, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single line
    d1 = {16{8'h5A}};
    enq(12'h0A3, d1);
    look("single_look", 12'h0A3, 1'b1, d1);
    @(negedge clk);
    check_eq("single_write_not_yet", {127'd0, pmem_write}, 128'd0);
    @(negedge clk);
    check_eq("single_write", {127'd0, pmem_write}, 128'd1);
    check_eq("single_addr", {112'd0, pmem_address}, 128'h0A30);
    check_eq("single_wdata", pmem_wdata, d1);
    drain_all(3, 50);
    @(negedge clk);
    check_eq("single_empty", {127'd0, empty}, 128'd1);
    check_eq("single_write_low", {127'd0, pmem_write}, 128'd0);
    check_eq("single_idle_addr", {112'd0, pmem_address}, 128'd0);

    // Fill with memory stalled
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) enq(12'h100 + 12'(i), {4{$urandom()}});
    #1;
    check_eq("fill_full", {127'd0, full}, 128'd1);
    check_eq("fill_count", {125'd0, count}, 128'd4);
    enq_addr = 12'h104;
    #1;
    check_eq("fill_ready_new", {127'd0, enq_ready}, 128'd0);
    enq_addr = 12'h100;
    #1;
    check_eq("fill_ready_head", {127'd0, enq_ready}, 128'd0);
    enq_addr = 12'h102;
    #1;
    check_eq("fill_ready_match", {127'd0, enq_ready}, 128'd1);
    d2 = {4{$urandom()}};
    enq(12'h102, d2);
    #1;
    check_eq("fill_count_after_coal", {125'd0, count}, 128'd4);
    look("fill_look", 12'h102, 1'b1, d2);
    drain_all(1, 100);

    // Coalesce behind a different head
    @(posedge clk);
    #1;
    enq(12'h001, {4{$urandom()}});
    @(posedge clk);
    #1;
    d1 = {4{$urandom()}};
    d2 = {4{$urandom()}};
    enq(12'h010, d1);
    enq(12'h010, d2);
    #1;
    check_eq("coal_count", {125'd0, count}, 128'd2);
    look("coal_look", 12'h010, 1'b1, d2);
    drain_all(2, 100);

    // Head frozen while in WRITE
    @(posedge clk);
    #1;
    d1 = {4{$urandom()}};
    d2 = {4{$urandom()}};
    enq(12'h020, d1);
    @(posedge clk);
    #1;
    check_eq("frozen_write", {127'd0, pmem_write}, 128'd1);
    enq(12'h020, d2);
    #1;
    check_eq("frozen_count", {125'd0, count}, 128'd2);
    look("frozen_look", 12'h020, 1'b1, d2);
    w0 = n_writes;
    drain_all(1, 100);
    check_eq("frozen_two_writes", 128'(n_writes - w0), 128'd2);

    // Simultaneous enqueue and pop, then one idle cycle between writes
    @(posedge clk);
    #1;
    enq(12'h030, {4{$urandom()}});
    enq(12'h031, {4{$urandom()}});
    #1;
    check_eq("simul_pre_count", {125'd0, count}, 128'd2);
    check_eq("simul_pre_write", {127'd0, pmem_write}, 128'd1);
    pmem_resp = 1'b1;
    enq(12'h032, {4{$urandom()}});
    pmem_resp = 1'b0;
    #1;
    check_eq("simul_count", {125'd0, count}, 128'd2);
    @(negedge clk);
    check_eq("b2b_idle_gap", {127'd0, pmem_write}, 128'd0);
    @(negedge clk);
    check_eq("b2b_rewrite", {127'd0, pmem_write}, 128'd1);
    drain_all(0, 100);

    // Wrap-around over ten entries
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      enq(12'h200 + 12'(i), {4{$urandom()}});
      if (i % 3 == 2) drain_all(1, 100);
    end
    drain_all(0, 100);
    check_eq("wrap_empty", {127'd0, empty}, 128'd1);

    // Reset asserted mid-WRITE
    @(posedge clk);
    #1;
    enq(12'h300, {4{$urandom()}});
    enq(12'h301, {4{$urandom()}});
    @(negedge clk);
    check_eq("rstw_write_before", {127'd0, pmem_write}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_write_drop", {127'd0, pmem_write}, 128'd0);
    check_eq("rstw_count", {125'd0, count}, 128'd0);
    check_eq("rstw_addr", {112'd0, pmem_address}, 128'd0);
    sb_addr.delete();
    sb_data.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstw_count_after", {125'd0, count}, 128'd0);
    check_eq("rstw_empty_after", {127'd0, empty}, 128'd1);
    look("rstw_look", 12'h300, 1'b0, 128'd0);
    repeat (3) @(negedge clk);
    check_eq("rstw_no_write", {127'd0, pmem_write}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
